alu_mult_seq: RTL and testbench
===============================

// Module: alu_mult_seq
// PURPOSE
//  Iterative 32x32->64 shift-add multiply sequencer for the DLX EX stage. Borrows the shared
//  ALU for one add per cycle, selected through alu_sel. Stalls the pipeline while running.
//  Handles MULT/MULTU; the EX stage owns the ALU whenever alu_sel is low.
// PARAMETERS
//  WIDTH      32        operand width; must match the ALU datapath
//  ALU_ADD_OP 5'b00010  ALU opcode driven on alu_op during iterations (add)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        request; accepted only in IDLE
//  mult_signed in   1        1=signed MULT, 0=MULTU; sampled with start
//  op_a        in   WIDTH    multiplicand; sampled with start
//  op_b        in   WIDTH    multiplier; sampled with start
//  flush       in   1        synchronous abort from the pipeline
//  alu_result  in   WIDTH    shared ALU Result
//  alu_carry   in   1        shared ALU Carryout
//  alu_a       out  WIDTH    ALU A operand (product high half)
//  alu_b       out  WIDTH    ALU B operand (multiplicand, or 0 when the multiplier bit is 0)
//  alu_op      out  5        ALU opcode
//  alu_sel     out  1        1 = the sequencer drives the ALU operand muxes
//  busy        out  1        stall request to the pipeline; high in RUN and DONE
//  done        out  1        one-cycle pulse; the product is valid
//  prod_hi     out  WIDTH    product bits [63:32]
//  prod_lo     out  WIDTH    product bits [31:0]
// BEHAVIOUR
//  Reset: state=IDLE, count=0, product=0, alu_sel=0, busy=0, done=0, alu_a=alu_b=0,
//   alu_op=ALU_ADD_OP.
//  FSM IDLE->RUN on start (and !flush). RUN->DONE after WIDTH iterations. DONE->IDLE
//   unconditionally. flush in RUN or DONE -> IDLE with no done pulse; the product is left stale.
//  Start edge: latch mcand=op_a, hi=0, lo=op_b, count=0.
//  RUN iteration, one per clk: alu_a=hi, alu_b = lo[0] ? mcand : 0, alu_op=ALU_ADD_OP.
//   Update {hi,lo} <= {alu_carry, alu_result, lo} >> 1. The 33-bit sum must not drop the carry.
//  Iteration count: count increments each RUN cycle; leave RUN on count==WIDTH-1.
//  Timing: start sampled at edge E0; iterations occur at edges E1..E32; done=1 in the cycle
//   after E32; the product is visible from that cycle.
//  Outputs: prod_hi/prod_lo hold until the next accepted start.
//   alu_sel=1 only in RUN; the ALU outputs are combinational into this block and are
//   registered here.
//  Boundary cases:
//   - start while busy: ignored.
//   - start and flush in the same IDLE cycle: flush wins; the request is not accepted.
//   - op_b=0 or op_a=0: still runs the full WIDTH cycles; no early exit.
//   - rst_n low mid-RUN: immediate return to reset values.
// CONFIGURATION
//  ALU_MULT_SIGNED_EN defined:
//   - if mult_signed=1, the start edge latches |op_a| and |op_b| and records the sign as
//     sign = op_a[31]^op_b[31].
//   - DONE presents the two's-complement 64-bit negation of {hi,lo} when sign=1, computed
//     combinationally from the registers.
//   - Latency is unchanged. 0x80000000 magnitude is handled as an unsigned 2^31.
//  Not defined: mult_signed is ignored; every operation is unsigned (MULTU).
// STRUCTURE
//  Shared package dlx_pkg: ALU opcode constants (ALU_AND..ALU_SGE, ALU_ADD=5'b00010),
//   mult FSM state typedef {IDLE, RUN, DONE}.
//  No sub-module required. The optional abs/negate logic may be split into mult_sign_fix.
//  The bench instantiates alu_mult_seq together with the existing behavioural alu.
// TESTING
//  1. op_a=3, op_b=5, MULTU -> done 33 cycles after start; {hi,lo}=0x00000000_0000000F.
//  2. op_a=op_b=0xFFFFFFFF, MULTU -> hi=0xFFFFFFFE, lo=0x00000001.
//     Exercises alu_carry capture every cycle.
//  3. Second start issued at cycle 10 of a run -> ignored.
//     done pulses exactly once; the result is from the first operands.
//  4. flush at cycle 12 -> IDLE next cycle, busy=0, no done.
//     A new start then completes normally: 7*6=42.
//  5. rst_n low at cycle 20 -> all outputs at reset values asynchronously.
//     After release, idle until start.
//  6. ALU_MULT_SIGNED_EN, mult_signed=1: -3*7 -> 0xFFFFFFFF_FFFFFFEB;
//     0x80000000*0x80000000 -> 0x40000000_00000000.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: ALU opcode encodings and the multiply sequencer state type.
package dlx_pkg;

  localparam int unsigned ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_SEQ = 5'b01001;
  localparam logic [ALU_OP_W-1:0] ALU_SNE = 5'b01010;
  localparam logic [ALU_OP_W-1:0] ALU_SLE = 5'b01011;
  localparam logic [ALU_OP_W-1:0] ALU_SGT = 5'b01100;
  localparam logic [ALU_OP_W-1:0] ALU_SGE = 5'b01101;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// Iterative shift-add multiplier that borrows the shared EX-stage ALU for one add per cycle.
// Define ALU_MULT_SIGNED_EN to support signed MULT via magnitude multiply and final negate.
module alu_mult_seq
  import dlx_pkg::*;
#(
  parameter int unsigned           WIDTH      = 32,
  parameter logic [ALU_OP_W-1:0]   ALU_ADD_OP = ALU_ADD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mult_signed,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic                flush,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_carry,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_sel,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    prod_hi,
  output logic [WIDTH-1:0]    prod_lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t        state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               accept_c;
  logic               last_c;
  logic [WIDTH-1:0]   a_mag_c;
  logic [WIDTH-1:0]   b_mag_c;
  logic [WIDTH-1:0]   hi_nxt_c;
  logic [WIDTH-1:0]   lo_nxt_c;

  // Next-state logic; flush always wins over start and over normal completion.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      MULT_IDLE: begin
        if (start && !flush) begin
          state_d  = MULT_RUN;
          accept_c = 1'b1;
        end
      end
      MULT_RUN: begin
        if (flush) begin
          state_d = MULT_IDLE;
        end else if (count_q == CNT_LAST) begin
          state_d = MULT_DONE;
          last_c  = 1'b1;
        end
      end
      MULT_DONE: state_d = MULT_IDLE;
      default:   state_d = MULT_IDLE;
    endcase
  end

  // Carry becomes the new top bit so the 33-bit partial sum is never truncated.
  always_comb begin
    hi_nxt_c = {alu_carry, alu_result[WIDTH-1:1]};
    lo_nxt_c = {alu_result[0], lo_q[WIDTH-1:1]};
  end

`ifdef ALU_MULT_SIGNED_EN
  logic sign_q;
  logic sign_c;

  // Signed requests are multiplied as magnitudes; the most negative value maps to unsigned 2^(W-1).
  always_comb begin
    sign_c  = mult_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    a_mag_c = (mult_signed && op_a[WIDTH-1]) ? (~op_a) + WIDTH'(1) : op_a;
    b_mag_c = (mult_signed && op_b[WIDTH-1]) ? (~op_b) + WIDTH'(1) : op_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else if (accept_c) begin
      sign_q <= sign_c;
    end
  end

  logic [PROD_W-1:0] prod_raw_c;
  logic [PROD_W-1:0] prod_fix_c;

  always_comb begin
    prod_raw_c = {hi_q, lo_q};
    prod_fix_c = sign_q ? (~prod_raw_c) + PROD_W'(1) : prod_raw_c;
    prod_hi    = prod_fix_c[PROD_W-1:WIDTH];
    prod_lo    = prod_fix_c[WIDTH-1:0];
  end
`else
  logic unused_mult_signed;

  always_comb begin
    unused_mult_signed = mult_signed;
    a_mag_c            = op_a;
    b_mag_c            = op_b;
    prod_hi            = hi_q;
    prod_lo            = lo_q;
  end
`endif

  // Datapath and registered ALU/pipeline handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MULT_IDLE;
      count_q <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= ALU_ADD_OP;
      alu_sel <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_op  <= ALU_ADD_OP;
      done    <= 1'b0;
      case (state_q)
        MULT_IDLE: begin
          if (accept_c) begin
            mcand_q <= a_mag_c;
            hi_q    <= '0;
            lo_q    <= b_mag_c;
            count_q <= '0;
            alu_a   <= '0;
            alu_b   <= b_mag_c[0] ? a_mag_c : '0;
            alu_sel <= 1'b1;
            busy    <= 1'b1;
          end
        end
        MULT_RUN: begin
          if (flush) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 1'b0;
            busy    <= 1'b0;
          end else begin
            hi_q    <= hi_nxt_c;
            lo_q    <= lo_nxt_c;
            count_q <= count_q + CNT_W'(1);
            if (last_c) begin
              alu_a   <= '0;
              alu_b   <= '0;
              alu_sel <= 1'b0;
              done    <= 1'b1;
            end else begin
              alu_a <= hi_nxt_c;
              alu_b <= lo_nxt_c[0] ? mcand_q : '0;
            end
          end
        end
        MULT_DONE: begin
          busy <= 1'b0;
        end
        default: begin
          alu_sel <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural stand-in for the shared ALU adder.
// Signed cases run only when ALU_MULT_SIGNED_EN is defined.
module tb_alu_mult_seq;
  import dlx_pkg::*;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mult_signed;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          flush;
  logic [W-1:0]  alu_result;
  logic          alu_carry;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [4:0]    alu_op;
  logic          alu_sel;
  logic          busy;
  logic          done;
  logic [W-1:0]  prod_hi;
  logic [W-1:0]  prod_lo;

  int checks;
  int errors;

  alu_mult_seq #(.WIDTH(W), .ALU_ADD_OP(ALU_ADD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mult_signed(mult_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sel(alu_sel),
    .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo)
  );

  // Behavioural shared ALU: only the add path matters to the sequencer.
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum    = (alu_op == ALU_ADD) ? ({1'b0, alu_a} + {1'b0, alu_b}) : '0;
    alu_result = alu_sum[W-1:0];
    alu_carry  = alu_sum[W];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    op_a        = a;
    op_b        = b;
    mult_signed = s;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // Latency counted in cycles from the cycle start is asserted; bounded wait.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_done"},    64'(done),    64'd0);
    chk({tag, "_alu_sel"}, 64'(alu_sel), 64'd0);
    chk({tag, "_alu_a"},   64'(alu_a),   64'd0);
    chk({tag, "_alu_b"},   64'(alu_b),   64'd0);
    chk({tag, "_alu_op"},  64'(alu_op),  64'(ALU_ADD));
    chk({tag, "_prod"},    {prod_hi, prod_lo}, 64'd0);
  endtask

  int lat;
  int pulses;
  int pulse_lat;
  logic [63:0] cap;

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    flush       = 1'b0;
    mult_signed = 1'b0;
    op_a        = '0;
    op_b        = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 3 * 5 unsigned, with first-cycle ALU drive checks
    start_op(32'd3, 32'd5, 1'b0);
    chk("t1_alu_sel_run", 64'(alu_sel), 64'd1);
    chk("t1_busy_run",    64'(busy),    64'd1);
    chk("t1_alu_b_first", 64'(alu_b),   64'd3);
    wait_done(lat);
    chk("t1_latency", 64'(lat), 64'd33);
    chk("t1_prod", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);
    chk("t1_busy_done", 64'(busy), 64'd1);
    chk("t1_alu_sel_done", 64'(alu_sel), 64'd0);
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_busy_idle", 64'(busy), 64'd0);
    chk("t1_prod_hold", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);

    // all-ones squared: carry is captured every cycle
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat);
    chk("t2_latency", 64'(lat), 64'd33);
    chk("t2_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);

    // second start while busy is ignored
    start_op(32'h0001_0000, 32'h0001_0000, 1'b0);
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
    end
    op_a  = 32'd2;
    op_b  = 32'd2;
    start = 1'b1;
    @(negedge clk);
    lat++;
    start  = 1'b0;
    pulses = 0;
    pulse_lat = 0;
    cap = '0;
    while (lat < 80) begin
      if (done) begin
        pulses++;
        pulse_lat = lat;
        cap = {prod_hi, prod_lo};
      end
      @(negedge clk);
      lat++;
    end
    chk("t3_pulses", 64'(pulses), 64'd1);
    chk("t3_latency", 64'(pulse_lat), 64'd33);
    chk("t3_prod", cap, 64'h0000_0001_0000_0000);

    // flush mid-run aborts without a done pulse
    start_op(32'd100, 32'd100, 1'b0);
    lat = 1;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_busy_flush", 64'(busy), 64'd0);
    chk("t4_alu_sel_flush", 64'(alu_sel), 64'd0);
    pulses = 0;
    repeat (40) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("t4_no_done", 64'(pulses), 64'd0);
    start_op(32'd7, 32'd6, 1'b0);
    wait_done(lat);
    chk("t4_latency", 64'(lat), 64'd33);
    chk("t4_prod", {prod_hi, prod_lo}, 64'd42);
    @(negedge clk);

    // start and flush together in IDLE: flush wins
    @(negedge clk);
    op_a  = 32'd9;
    op_b  = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("t4_startflush_busy", 64'(busy), 64'd0);
    chk("t4_startflush_sel", 64'(alu_sel), 64'd0);
    chk("t4_startflush_prod", {prod_hi, prod_lo}, 64'd42);

    // asynchronous reset mid-run
    start_op(32'd9, 32'd9, 1'b0);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done || alu_sel) pulses++;
    end
    chk("t5_idle_after", 64'(pulses), 64'd0);

    // zero operand still takes the full latency
    start_op(32'd0, 32'd5, 1'b0);
    wait_done(lat);
    chk("t5_zero_latency", 64'(lat), 64'd33);
    chk("t5_zero_prod", {prod_hi, prod_lo}, 64'd0);

`ifdef ALU_MULT_SIGNED_EN
    start_op(32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(lat);
    chk("t6_neg_latency", 64'(lat), 64'd33);
    chk("t6_neg_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(lat);
    chk("t6_min_prod", {prod_hi, prod_lo}, 64'h4000_0000_0000_0000);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
